rsa_muldiv: RTL and testbench

Sequential arithmetic engine for the RSA encryption datapath: a WIDTH×WIDTH shift-add multiplier and a WIDTH/WIDTH restoring divider. The two engines run independently and share only clock and reset. The modular-exponentiation controller uses them as multiply-then-reduce: it sends the product to the divider and takes the remainder as the new cipher value.

---
 rtl/rsa_pkg.sv | 19 +
 rtl/rsa_div_core.sv | 101 ++++++++++
 rtl/rsa_muldiv.sv | 91 +++++++++
 tb/tb_rsa_muldiv.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared constants and types for the RSA multiply/divide engines.
// Optional feature macro used by this slice: RSA_MULDIV_DIV0_CHECK_EN.
package rsa_pkg;

  localparam int RSA_WIDTH = 128;

  localparam int RSA_CNT_W = $clog2(RSA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } eng_state_t;

  function automatic int rsa_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/rsa_div_core.sv
// rsa_div_core: unsigned restoring divider, one quotient bit per cycle.
// RSA_MULDIV_DIV0_CHECK_EN adds a one-cycle divide-by-zero shortcut.
module rsa_div_core
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
`ifdef RSA_MULDIV_DIV0_CHECK_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int CW = rsa_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  eng_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   r_sh;
  logic             fits;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;
`ifdef RSA_MULDIV_DIV0_CHECK_EN
  logic             zero;
`endif

  // One restoring step: shift, trial-subtract, keep on no borrow.
  // Remainder stays below the divisor, so the W-bit difference is exact.
  assign r_sh  = {r, q[WIDTH-1]};
  assign fits  = (r_sh >= {1'b0, m});
  assign r_nxt = fits ? (r_sh[WIDTH-1:0] - m) : r_sh[WIDTH-1:0];
  assign q_nxt = {q[WIDTH-2:0], fits};

  // Divider FSM and datapath; start always relatches and restarts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      m         <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
`ifdef RSA_MULDIV_DIV0_CHECK_EN
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else if (start) begin
      state <= RUN;
      cnt   <= '0;
      r     <= '0;
      q     <= dividend;
      m     <= divisor;
      done  <= 1'b0;
`ifdef RSA_MULDIV_DIV0_CHECK_EN
      zero        <= (divisor == '0);
      div_by_zero <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
`ifdef RSA_MULDIV_DIV0_CHECK_EN
          if (zero) begin
            quotient    <= '1;
            remainder   <= q;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
`else
          begin
`endif
            r   <= r_nxt;
            q   <= q_nxt;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              quotient  <= q_nxt;
              remainder <= r_nxt;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rsa_muldiv.sv
// rsa_muldiv: shift-add multiplier plus restoring divider for RSA datapath.
// Optional macro RSA_MULDIV_DIV0_CHECK_EN exposes div_by_zero.
module rsa_muldiv
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mult_start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] c_mult,
  output logic               mult_done,
  input  logic               div_start,
  input  logic [WIDTH-1:0]   dividend_q,
  input  logic [WIDTH-1:0]   divisor_m,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_done
`ifdef RSA_MULDIV_DIV0_CHECK_EN
  ,
  output logic               div_by_zero
`endif
);

  localparam int CW = rsa_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  eng_state_t         m_state;
  logic [CW-1:0]      m_cnt;
  logic [2*WIDTH-1:0] m_a;
  logic [WIDTH-1:0]   m_b;
  logic [2*WIDTH-1:0] m_acc;
  logic [2*WIDTH-1:0] m_sum;

  assign m_sum = m_acc + (m_b[0] ? m_a : '0);

  // Multiplier: LSB-first, multiplicand shifts left each iteration.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_state   <= IDLE;
      m_cnt     <= '0;
      m_a       <= '0;
      m_b       <= '0;
      m_acc     <= '0;
      c_mult    <= '0;
      mult_done <= 1'b0;
    end else if (mult_start) begin
      m_state   <= RUN;
      m_cnt     <= '0;
      m_a       <= {{WIDTH{1'b0}}, a};
      m_b       <= b;
      m_acc     <= '0;
      mult_done <= 1'b0;
    end else begin
      case (m_state)
        RUN: begin
          m_acc <= m_sum;
          m_a   <= m_a << 1;
          m_b   <= m_b >> 1;
          m_cnt <= m_cnt + CW'(1);
          if (m_cnt == LAST) begin
            c_mult    <= m_sum;
            mult_done <= 1'b1;
            m_state   <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

  rsa_div_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (div_start),
    .dividend   (dividend_q),
    .divisor    (divisor_m),
    .quotient   (quotient),
    .remainder  (remainder),
    .done       (div_done)
`ifdef RSA_MULDIV_DIV0_CHECK_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

endmodule

// File: tb/tb_rsa_muldiv.sv
// tb_rsa_muldiv: directed vectors with queue scoreboard and done monitor.
// Honors RSA_MULDIV_DIV0_CHECK_EN for divide-by-zero expectations.
module tb_rsa_muldiv;

  localparam int W = 128;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           mult_start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2*W-1:0] c_mult;
  logic           mult_done;
  logic           div_start = 1'b0;
  logic [W-1:0]   dividend_q = '0;
  logic [W-1:0]   divisor_m = '0;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_done;
`ifdef RSA_MULDIV_DIV0_CHECK_EN
  logic           div_by_zero;
`endif

  rsa_muldiv #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mult_start (mult_start),
    .a          (a),
    .b          (b),
    .c_mult     (c_mult),
    .mult_done  (mult_done),
    .div_start  (div_start),
    .dividend_q (dividend_q),
    .divisor_m  (divisor_m),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_done   (div_done)
`ifdef RSA_MULDIV_DIV0_CHECK_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    longint         t;
    int             lat;
  } m_exp_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    longint       t;
    int           lat;
  } d_exp_t;

  m_exp_t mq[$];
  d_exp_t dq[$];

  longint cyc = 0;
  int     n_run = 0;
  int     n_fail = 0;
  logic   m_prev = 1'b0;
  logic   d_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [2*W-1:0] act,
                     input logic [2*W-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a rising done pops the oldest expectation and compares.
  always @(negedge clk) begin
    if (mult_done && !m_prev) begin
      if (mq.size() == 0) begin
        chk("mult_unexpected_done", 1, 0);
      end else begin
        m_exp_t e;
        e = mq.pop_front();
        chk("mult_product", c_mult, e.p);
        chk("mult_latency", 256'(cyc - e.t), 256'(e.lat));
      end
    end
    if (div_done && !d_prev) begin
      if (dq.size() == 0) begin
        chk("div_unexpected_done", 1, 0);
      end else begin
        d_exp_t e;
        e = dq.pop_front();
        chk("div_quotient", 256'(quotient), 256'(e.q));
        chk("div_remainder", 256'(remainder), 256'(e.r));
        chk("div_latency", 256'(cyc - e.t), 256'(e.lat));
`ifdef RSA_MULDIV_DIV0_CHECK_EN
        chk("div_by_zero", 256'(div_by_zero), 256'(e.dz));
`endif
      end
    end
    m_prev = mult_done;
    d_prev = div_done;
  end

  function automatic int div_lat(input logic [W-1:0] m);
`ifdef RSA_MULDIV_DIV0_CHECK_EN
    return (m == '0) ? 1 : W;
`else
    return W;
`endif
  endfunction

  task automatic push_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [2*W-1:0] p);
    m_exp_t e;
    mq.delete();
    a = x;
    b = y;
    mult_start = 1'b1;
    e.p = p;
    e.t = cyc + 1;
    e.lat = W;
    mq.push_back(e);
  endtask

  task automatic push_div(input logic [W-1:0] n, input logic [W-1:0] m,
                          input logic [W-1:0] q, input logic [W-1:0] r);
    d_exp_t e;
    dq.delete();
    dividend_q = n;
    divisor_m = m;
    div_start = 1'b1;
    e.q = q;
    e.r = r;
    e.dz = (m == '0);
    e.t = cyc + 1;
    e.lat = div_lat(m);
    dq.push_back(e);
  endtask

  // Drop the start pulses and scramble operands to prove they were latched.
  task automatic end_pulse();
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    div_start = 1'b0;
    a = '1;
    b = '1;
    dividend_q = '1;
    divisor_m = 128'd3;
  endtask

  task automatic do_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2*W-1:0] p);
    @(posedge clk);
    #1;
    push_mult(x, y, p);
    end_pulse();
  endtask

  task automatic do_div(input logic [W-1:0] n, input logic [W-1:0] m,
                        input logic [W-1:0] q, input logic [W-1:0] r);
    @(posedge clk);
    #1;
    push_div(n, m, q, r);
    end_pulse();
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((mq.size() != 0 || dq.size() != 0) && c < 400) begin
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    if (mq.size() != 0 || dq.size() != 0) begin
      chk("done_timeout", 1, 0);
      mq.delete();
      dq.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_c_mult"}, c_mult, '0);
    chk({tag, "_mult_done"}, 256'(mult_done), '0);
    chk({tag, "_quotient"}, 256'(quotient), '0);
    chk({tag, "_remainder"}, 256'(remainder), '0);
    chk({tag, "_div_done"}, 256'(div_done), '0);
`ifdef RSA_MULDIV_DIV0_CHECK_EN
    chk({tag, "_div_by_zero"}, 256'(div_by_zero), '0);
`endif
  endtask

  logic [2*W-1:0] max_p;

  initial begin
    max_p = {{(W-1){1'b1}}, 1'b0, {(W-1){1'b0}}, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;

    do_mult(128'd3, 128'd5, 256'd15);
    wait_idle();
    repeat (10) @(posedge clk);
    #1;
    chk("mult_hold_done", 256'(mult_done), 256'd1);
    chk("mult_hold_value", c_mult, 256'd15);

    do_mult('1, '1, max_p);
    wait_idle();

    do_div(128'd100, 128'd7, 128'd14, 128'd2);
    wait_idle();
    do_div(128'd5, 128'd9, 128'd0, 128'd5);
    wait_idle();
    do_div(128'd42, 128'd0, '1, 128'd42);
    wait_idle();

    @(posedge clk);
    #1;
    push_mult(128'd1234, 128'd5678, 256'd7006652);
    push_div(128'd1000, 128'd33, 128'd30, 128'd10);
    end_pulse();
    wait_idle();

    @(posedge clk);
    #1;
    push_mult(128'd7, 128'd9, 256'd63);
    push_div(128'd200, 128'd15, 128'd13, 128'd5);
    end_pulse();
    repeat (40) @(posedge clk);
    #1;
    push_mult(128'd11, 128'd13, 256'd143);
    end_pulse();
    wait_idle();

    @(posedge clk);
    #1;
    push_mult(128'd6, 128'd7, 256'd42);
    push_div(128'd50, 128'd8, 128'd6, 128'd2);
    end_pulse();
    repeat (62) @(posedge clk);
    #1;
    reset_n = 1'b0;
    mq.delete();
    dq.delete();
    @(posedge clk);
    #1;
    chk_zero("midreset");
    reset_n = 1'b1;

    @(posedge clk);
    #1;
    push_mult(128'd6, 128'd7, 256'd42);
    push_div(128'd50, 128'd8, 128'd6, 128'd2);
    end_pulse();
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
